// File: rtl/hwpe_stream_source_sequencer_pkg.sv
// Shared types for the source-streamer job sequencer: addressgen descriptor,
// source/sink control plane and the sequencer FSM encoding.
package hwpe_stream_source_sequencer_pkg;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_roll;
    logic        loop_outer;
    logic        realign_type;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic             req_start;
    ctrl_addressgen_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_START = 2'd1,
    SEQ_RUN   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/hwpe_stream_job_queue.sv
// In-order circular descriptor queue; push valid/ready, pop enable, head and count.
module hwpe_stream_job_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter type         T           = logic
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           push_valid_i,
  output logic                           push_ready_o,
  input  T                               push_data_i,
  input  logic                           pop_i,
  output T                               head_o,
  output logic [$clog2(QUEUE_DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(QUEUE_DEPTH);

  T              mem [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic          push;

  // Ready depends on registered count only, so a full queue refuses a push
  // even when the same cycle pops.
  assign push_ready_o = (count_q < DEPTH_C);
  assign push         = push_valid_i & push_ready_o;
  assign head_o       = mem[rd_ptr_q];
  assign count_o      = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/hwpe_stream_source_sequencer.sv
// Job sequencer for one hwpe_stream_source: queues descriptors, launches them
// in order, holds the active descriptor and reports per-job completion.
module hwpe_stream_source_sequencer
  import hwpe_stream_source_sequencer_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  ctrl_addressgen_t             job_i,
  output ctrl_sourcesink_t             ctrl_o,
  input  flags_sourcesink_t            flags_i,
  output logic                         busy_o,
  output logic                         evt_done_o,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count_o,
  output logic [CNT_WIDTH-1:0]         jobs_done_o
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  seq_state_t           state_q;
  ctrl_addressgen_t     cur_q;
  ctrl_addressgen_t     head;
  logic                 req_start_q;
  logic                 evt_done_q;
  logic [CNT_WIDTH-1:0] jobs_done_q;
  logic [CW-1:0]        count;
  logic                 launch, done_run, pop;

  hwpe_stream_job_queue #(
    .QUEUE_DEPTH ( QUEUE_DEPTH       ),
    .T           ( ctrl_addressgen_t )
  ) i_job_queue (
    .clk_i        ( clk_i       ),
    .rst_ni       ( rst_ni      ),
    .clear_i      ( clear_i     ),
    .push_valid_i ( job_valid_i ),
    .push_ready_o ( job_ready_o ),
    .push_data_i  ( job_i       ),
    .pop_i        ( pop         ),
    .head_o       ( head        ),
    .count_o      ( count       )
  );

  assign launch   = (count != '0) & flags_i.ready_start;
  assign done_run = (state_q == SEQ_RUN) & flags_i.done;
  assign pop      = launch & ((state_q == SEQ_IDLE) | done_run);

  // done outside SEQ_RUN never reaches done_run, so it is neither counted nor pulsed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SEQ_IDLE;
      cur_q       <= '0;
      req_start_q <= 1'b0;
      evt_done_q  <= 1'b0;
      jobs_done_q <= '0;
    end else if (clear_i) begin
      state_q     <= SEQ_IDLE;
      cur_q       <= '0;
      req_start_q <= 1'b0;
      evt_done_q  <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      req_start_q <= 1'b0;
      evt_done_q  <= 1'b0;
      case (state_q)
        SEQ_IDLE: begin
          if (pop) begin
            cur_q       <= head;
            req_start_q <= 1'b1;
            state_q     <= SEQ_START;
          end
        end
        SEQ_START: state_q <= SEQ_RUN;
        SEQ_RUN: begin
          if (done_run) begin
            evt_done_q  <= 1'b1;
            jobs_done_q <= jobs_done_q + CNT_WIDTH'(1);
            if (pop) begin
              cur_q       <= head;
              req_start_q <= 1'b1;
              state_q     <= SEQ_START;
            end else begin
              state_q <= SEQ_IDLE;
            end
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  assign ctrl_o.req_start       = req_start_q;
  assign ctrl_o.addressgen_ctrl = cur_q;
  assign evt_done_o             = evt_done_q;
  assign jobs_done_o            = jobs_done_q;
  assign queue_count_o          = count;
  assign busy_o                 = (state_q != SEQ_IDLE) | (count != '0);

endmodule

// File: doc/hwpe_stream_source_sequencer.md
# hwpe_stream_source_sequencer

Job sequencer for one `hwpe_stream_source` streamer. Accepts addressgen job descriptors through a valid/ready push port and buffers them in a small in-order queue. Launches each job on the streamer through its `ctrl_sourcesink_t` / `flags_sourcesink_t` control plane and holds the descriptor stable while the job runs. Reports per-job completion, so the HWPE controller can post several transfers back-to-back without handling each `done` itself.

## Interface
Parameters:
- `QUEUE_DEPTH`, 4: descriptor queue entries; power of two, ≥2.
- `CNT_WIDTH`, 16: width of the completed-job counter.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous clear; same effect as reset.
- `job_valid_i`  in  1  descriptor push valid.
- `job_ready_o`  out  1  queue can accept; equals count<QUEUE_DEPTH.
- `job_i`  in  `ctrl_addressgen_t`  descriptor.
- `ctrl_o`  out  `ctrl_sourcesink_t`  to streamer: `req_start` plus `addressgen_ctrl`.
- `flags_i`  in  `flags_sourcesink_t`  from streamer; uses `ready_start` and `done`.
- `busy_o`  out  1  FSM not IDLE or queue non-empty.
- `evt_done_o`  out  1  one-cycle pulse per completed job.
- `queue_count_o`  out  $clog2(QUEUE_DEPTH)+1  queued (not yet launched) jobs.
- `jobs_done_o`  out  CNT_WIDTH  completed jobs since reset/clear; wraps modulo 2^CNT_WIDTH.

## Operation
- **Queue:** circular buffer with `rd_ptr`, `wr_ptr` and `count`.
  - Push when `job_valid_i & job_ready_o`.
  - Pop only from the FSM launch condition.
  - Push and pop in the same cycle leave `count` unchanged.
  - No bypass: a job pushed into an empty queue is visible one cycle later.
  - `job_ready_o` does not depend on a same-cycle pop, so when full a push is refused even if a pop occurs.
- **Current-job register `cur`:** loaded on pop.
  - `ctrl_o.addressgen_ctrl = cur` at all times.
  - `cur` is stable from launch until `done`, because the streamer reads `trans_size` throughout the job.
- **FSM states:** `SEQ_IDLE`, `SEQ_START`, `SEQ_RUN`.
- **Launch condition:** `count!=0 & flags_i.ready_start`.
- **SEQ_IDLE:** if the launch condition holds, pop, load `cur`, go to `SEQ_START`; otherwise stay.
- **SEQ_START:** `ctrl_o.req_start=1` for exactly this one cycle; go to `SEQ_RUN` unconditionally.
- **SEQ_RUN:** wait for `flags_i.done`. On `done`:
  - set `evt_done_o` next cycle;
  - increment `jobs_done_o` at the same edge that sets `evt_done_o`;
  - if the launch condition also holds this cycle, pop and go directly to `SEQ_START` (back-to-back);
  - otherwise go to `SEQ_IDLE`.
- **`flags_i.done` outside `SEQ_RUN`:** ignored; not counted.
- **`ready_start` low in `SEQ_IDLE`:** job stays queued; no pop.
- **`busy_o`:** `(state!=SEQ_IDLE) | (count!=0)`.

## Timing
- **Reset and clear values:**
  - state `SEQ_IDLE`, `count`/pointers 0, `cur` 0;
  - `req_start` 0, `evt_done_o` 0, `jobs_done_o` 0, `queue_count_o` 0, `busy_o` 0;
  - `job_ready_o` 1.
- **Launch latency:** push accepted at edge of cycle 0 → pop in cycle 1 (if `ready_start`) → `req_start` high in cycle 2.
- **Back-to-back:** `done` in cycle N → `req_start` for the next job in cycle N+1, with no gap cycle.
- **Completion:** `evt_done_o` high in cycle N+1 for `done` in cycle N; `jobs_done_o` updated in cycle N+1.
- **`clear_i` or reset mid-job:**
  - queue flushed; in-flight job dropped;
  - no `evt_done_o`; counter zeroed;
  - `req_start` low from the next cycle.
  - The streamer is cleared by the same `clear_i` at top level.
- **`clear_i` coincident with a push:** clear wins; the push is lost.
- **Counter wrap:** `2^CNT_WIDTH-1 → 0` with `evt_done_o` still pulsed.
- All outputs are registered except `job_ready_o`, `busy_o`, `queue_count_o` and `ctrl_o.addressgen_ctrl`, which are decoded from registers only. There is no input→output combinational path.

## Structure
- `hwpe_stream_package`: add `seq_state_t` enum {`SEQ_IDLE`, `SEQ_START`, `SEQ_RUN`}.
- `ctrl_addressgen_t`, `ctrl_sourcesink_t` and `flags_sourcesink_t` are reused unchanged.
- Sub-module `hwpe_stream_job_queue`, parameterised on `QUEUE_DEPTH`, type-parametric on the descriptor. It provides:
  - push valid/ready;
  - pop enable;
  - head data;
  - count.
- The sequencer holds the FSM, `cur`, the event pulse and the counter.

## Test plan
- Single job (`trans_size`=8), streamer `done` 20 cycles after `req_start` → one-cycle `req_start` 2 cycles after push; `addressgen_ctrl` equals the descriptor through `done`; `evt_done_o` one cycle later; `jobs_done_o`=1; `busy_o` low afterwards.
- Push 4 jobs back-to-back with DEPTH=4, streamer busy → `job_ready_o` low at `count`=4; 5th push refused; jobs launched in push order; each `req_start` exactly 1 cycle after the previous `done`.
- `ready_start` held low for 10 cycles with 2 jobs queued → no pop, no `req_start`; launch on the first cycle `ready_start` rises.
- `clear_i` during `SEQ_RUN` with 2 jobs queued → `queue_count_o`=0, state IDLE, no `evt_done_o`, `jobs_done_o`=0; a later push launches normally.
- `CNT_WIDTH`=2, run 5 jobs → `jobs_done_o` sequence 1,2,3,0,1; 5 `evt_done_o` pulses.
- Spurious `done` in IDLE, plus simultaneous push and pop at `count`=2 → counter unchanged by the spurious `done`; `count` stays 2 for the push+pop.
